// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 default timing for the VGA raster generator.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT_PORCH,
        SYNC,
        BACK_PORCH
    } vga_region_t;

    localparam int VGA_X_MAX_W = 16;

    typedef struct packed {
        logic                   hs;
        logic                   vs;
        logic                   de;
        logic [VGA_X_MAX_W-1:0] x;
    } vga_sync_t;

    localparam int VGA_640_H_ACTIVE = 640;
    localparam int VGA_640_H_FP     = 16;
    localparam int VGA_640_H_SYNC   = 96;
    localparam int VGA_640_H_BP     = 48;
    localparam int VGA_640_V_ACTIVE = 480;
    localparam int VGA_640_V_FP     = 10;
    localparam int VGA_640_V_SYNC   = 2;
    localparam int VGA_640_V_BP     = 33;

    function automatic vga_region_t region_of(input int cnt, input int act,
                                              input int fp, input int sync_w);
        if (cnt < act)
            return ACTIVE;
        else if (cnt < act + fp)
            return FRONT_PORCH;
        else if (cnt < act + fp + sync_w)
            return SYNC;
        else
            return BACK_PORCH;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages with synchronous reset to RESET_VAL.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                stage[i] <= RESET_VAL;
        end else if (en) begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator and pixel-output stage.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_640_H_ACTIVE,
    parameter int   H_FP     = VGA_640_H_FP,
    parameter int   H_SYNC   = VGA_640_H_SYNC,
    parameter int   H_BP     = VGA_640_H_BP,
    parameter int   V_ACTIVE = VGA_640_V_ACTIVE,
    parameter int   V_FP     = VGA_640_V_FP,
    parameter int   V_SYNC   = VGA_640_V_SYNC,
    parameter int   V_BP     = VGA_640_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   COLOR_W  = 8,
    parameter int   LATENCY  = 1,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW       = $clog2(H_TOTAL),
    localparam int  YW       = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    output logic [XW-1:0]        req_x,
    output logic [YW-1:0]        req_y,
    output logic                 req_valid,
    output logic                 line_start,
    output logic                 frame_start,
    input  logic [3*COLOR_W-1:0] colour_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 blank,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    vga_region_t   h_reg, v_reg;
    logic          hs_raw, vs_raw;
    logic          dly_hs, dly_vs, dly_de;
    logic [3*COLOR_W-1:0] pix_colour;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        h_reg  = region_of(int'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
        v_reg  = region_of(int'(v_cnt), V_ACTIVE, V_FP, V_SYNC);
        hs_raw = (h_reg == SYNC) ? H_POL : ~H_POL;
        vs_raw = (v_reg == SYNC) ? V_POL : ~V_POL;
    end

    assign req_x       = h_cnt;
    assign req_y       = v_cnt;
    assign req_valid   = (h_reg == ACTIVE) && (v_reg == ACTIVE);
    assign line_start  = (h_cnt == '0);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [XW+2:0] H_ACT_W = (XW+3)'(H_ACTIVE);

    vga_sync_t     sync_in, sync_dly;
    logic [XW+2:0] x_scaled;

    always_comb begin
        sync_in    = '0;
        sync_in.hs = hs_raw;
        sync_in.vs = vs_raw;
        sync_in.de = req_valid;
        sync_in.x  = VGA_X_MAX_W'(h_cnt);
    end

    vga_delay_line #(
        .WIDTH     ($bits(vga_sync_t)),
        .DEPTH     (LATENCY),
        .RESET_VAL ({~H_POL, ~V_POL, 1'b0, {VGA_X_MAX_W{1'b0}}})
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (sync_in),
        .q   (sync_dly)
    );

    assign dly_hs = sync_dly.hs;
    assign dly_vs = sync_dly.vs;
    assign dly_de = sync_dly.de;

    // Bar index is x*8/H_ACTIVE; only meaningful while the delayed pixel is visible.
    always_comb begin
        x_scaled   = {sync_dly.x[XW-1:0], 3'b000} / H_ACT_W;
        pix_colour = colour_in;
        if (test_mode)
            pix_colour = {{COLOR_W{x_scaled[2]}}, {COLOR_W{x_scaled[1]}},
                          {COLOR_W{x_scaled[0]}}};
    end
`else
    logic [2:0] sync_dly;

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (LATENCY),
        .RESET_VAL ({~H_POL, ~V_POL, 1'b0})
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   ({hs_raw, vs_raw, req_valid}),
        .q   (sync_dly)
    );

    assign {dly_hs, dly_vs, dly_de} = sync_dly;
    assign pix_colour = colour_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            de    <= 1'b0;
            blank <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pix_en) begin
            hsync <= dly_hs;
            vsync <= dly_vs;
            de    <= dly_de;
            blank <= dly_de;
            red   <= dly_de ? pix_colour[3*COLOR_W-1:2*COLOR_W] : '0;
            green <= dly_de ? pix_colour[2*COLOR_W-1:COLOR_W]   : '0;
            blue  <= dly_de ? pix_colour[COLOR_W-1:0]           : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 14x7 raster with LATENCY 2; a second
// instance uses active-high syncs (and the colour-bar pattern under VGA_TEST_PATTERN_EN).
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LAT = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    logic [3*CW-1:0] colour_in = '0;
    logic test_mode = 1'b1;

    logic [3:0] req_x;
    logic [2:0] req_y;
    logic req_valid, line_start, frame_start;
    logic hsync0, vsync0, de0, blank0;
    logic [CW-1:0] r0, g0, b0;

    logic [3:0] req_x1;
    logic [2:0] req_y1;
    logic req_valid1, line_start1, frame_start1;
    logic hsync1, vsync1, de1, blank1;
    logic [CW-1:0] r1, g1, b1;

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(CW), .LATENCY(LAT)
    ) dut0 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
        .line_start(line_start), .frame_start(frame_start),
        .colour_in(colour_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .hsync(hsync0), .vsync(vsync0), .de(de0), .blank(blank0),
        .red(r0), .green(g0), .blue(b0)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(CW), .LATENCY(LAT)
    ) dut1 (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .req_x(req_x1), .req_y(req_y1), .req_valid(req_valid1),
        .line_start(line_start1), .frame_start(frame_start1),
        .colour_in(colour_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .hsync(hsync1), .vsync(vsync1), .de(de1), .blank(blank1),
        .red(r1), .green(g1), .blue(b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic int px(input int idx);
        return (idx % FRAME) % HT;
    endfunction

    function automatic int py(input int idx);
        return (idx % FRAME) / HT;
    endfunction

    function automatic bit visible(input int idx);
        return px(idx) < HA && py(idx) < VA;
    endfunction

    // Compare every output against the pixel model for the current strobe count k.
    task automatic check_all();
        int o, x, y;
        bit hs_on, vs_on, vis;
        logic [CW-1:0] er, eg, eb, br, bg, bb;
        chk("req_x", 32'(req_x), 32'(px(k)));
        chk("req_y", 32'(req_y), 32'(py(k)));
        chk("req_valid", 32'(req_valid), 32'(visible(k)));
        chk("line_start", 32'(line_start), 32'(px(k) == 0));
        chk("frame_start", 32'(frame_start), 32'(px(k) == 0 && py(k) == 0));
        o = k - 1 - LAT;
        hs_on = 1'b0; vs_on = 1'b0; vis = 1'b0;
        er = '0; eg = '0; eb = '0; br = '0; bg = '0; bb = '0;
        if (o >= 0) begin
            x = px(o);
            y = py(o);
            hs_on = (x >= HA + HF) && (x < HA + HF + HS);
            vs_on = (y >= VA + VF) && (y < VA + VF + VS);
            vis = visible(o);
            if (vis) begin
                er = CW'(x); eg = CW'(y); eb = CW'(x ^ y);
                br = {CW{x[2]}}; bg = {CW{x[1]}}; bb = {CW{x[0]}};
            end
        end
        chk("hsync0", 32'(hsync0), 32'(!hs_on));
        chk("vsync0", 32'(vsync0), 32'(!vs_on));
        chk("de0", 32'(de0), 32'(vis));
        chk("blank0", 32'(blank0), 32'(vis));
        chk("rgb0", {8'h0, r0, g0, b0}, {8'h0, er, eg, eb});
        chk("hsync1", 32'(hsync1), 32'(hs_on));
        chk("vsync1", 32'(vsync1), 32'(vs_on));
        chk("de1", 32'(de1), 32'(vis));
`ifdef VGA_TEST_PATTERN_EN
        chk("rgb1_bars", {8'h0, r1, g1, b1}, {8'h0, br, bg, bb});
`else
        chk("rgb1", {8'h0, r1, g1, b1}, {8'h0, er, eg, eb});
`endif
    endtask

    // One clock: the renderer answers the request made LAT strobes earlier.
    task automatic step(input logic en, input logic r);
        int ridx;
        ridx = k - LAT;
        pix_en = en;
        rst = r;
        if (ridx >= 0 && visible(ridx))
            colour_in = {CW'(px(ridx)), CW'(py(ridx)), CW'(px(ridx) ^ py(ridx))};
        else
            colour_in = 24'($urandom);
        @(posedge clk);
        #1;
        if (r)
            k = 0;
        else if (en)
            k++;
        check_all();
    endtask

    initial begin
        int fs_cnt, rv_cnt, vs_low;
        bit found;

        // Reset and first frames at full rate
        step(1'($urandom), 1'b1);
        step(1'($urandom), 1'b1);
        chk("reset_req_x", 32'(req_x), 32'd0);
        chk("reset_frame_start", 32'(frame_start), 32'd1);
        chk("reset_de", 32'(de0), 32'd0);

        fs_cnt = 0; rv_cnt = 0; vs_low = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 1'b0);
            fs_cnt += int'(frame_start);
            rv_cnt += int'(req_valid);
            vs_low += int'(!vsync0);
        end
        chk("frame_start_count", 32'(fs_cnt), 32'd2);
        chk("req_valid_count", 32'(rv_cnt), 32'(2 * HA * VA));
        chk("vsync_low_count", 32'(vs_low), 32'(2 * VS * HT));

        // One strobe in four
        for (int i = 0; i < 4 * FRAME + 20; i++)
            step(1'(i % 4 == 0), 1'b0);

        // Random strobe pattern
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'b0);

        // Seek h=5, v=3 and reset mid-frame
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (k % FRAME == 3 * HT + 5)
                found = 1'b1;
            else
                step(1'b1, 1'b0);
        end
        chk("seek_bound", 32'(found), 32'd1);
        chk("pre_rst_x", 32'(req_x), 32'd5);
        step(1'($urandom), 1'b1);
        chk("rst_req_x", 32'(req_x), 32'd0);
        chk("rst_req_y", 32'(req_y), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd1);
        chk("rst_hsync", 32'(hsync0), 32'd1);
        chk("rst_vsync", 32'(vsync0), 32'd1);
        chk("rst_de", 32'(de0), 32'd0);

        for (int i = 0; i < FRAME + 10; i++)
            step(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
